drive_pwm_ctrl: RTL and testbench
=================================

Name: drive_pwm_ctrl

Overview:
- Parametrised N-channel H-bridge drive controller; successor to the fixed two-motor, two-speed drive logic in the top-level drive state machine.
- Accepts per-channel direction/duty commands over a valid/ready interface.
- Generates glitch-free PWM, inserts dead-time on direction reversal, enforces a duty ceiling, and provides a latched emergency stop for collision handling.
- Sits between the drive state machine and the H-bridge pins (hb_en/hb_in pairs).

Parameters:
- N_CH, 2, number of motor channels (1..8)
- PWM_PERIOD, 625000, clocks per PWM period (50 MHz / 80 Hz)
- DUTY_W, 20, width of duty fields; must hold PWM_PERIOD
- MAX_DUTY_PCT, 80, duty ceiling in percent of PWM_PERIOD (H-bridge 2.5 A stall limit)
- DEAD_PERIODS, 2, whole PWM periods of forced coast on FWD<->REV reversal
- RAMP_STEP, 31250, max change of active duty per period (used only with DRIVE_RAMP_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_ch  in  $clog2(N_CH) (min 1)  target channel
- cmd_dir  in  2  00 COAST, 01 FWD, 10 REV, 11 BRAKE
- cmd_duty  in  DUTY_W  requested on-time in clocks
- estop  in  1  collision/emergency stop request, level
- estop_clr  in  1  pulse; releases latched stop
- hb_en  out  N_CH  bridge enable (PWM)
- hb_in1  out  N_CH  bridge input 1
- hb_in2  out  N_CH  bridge input 2
- period_start  out  1  one-cycle pulse when counter == 0
- stopped  out  1  estop latched

Behaviour:
- Reset: counter=0; all channels COAST, active and target duty 0; hb_en=0, hb_in1=0, hb_in2=0; stopped=0; cmd_ready=1; period_start=0.
- Shared counter cnt runs 0..PWM_PERIOD-1 and wraps; period_start=1 in the cycle cnt==0.
- Command accept: valid&&ready writes the pending target {dir,duty} of cmd_ch the same cycle. Multiple accepts to one channel within a period: last wins. cmd_ch >= N_CH is accepted and discarded.
- Duty clamp: stored duty = min(cmd_duty, MAX_DUTY), where MAX_DUTY = PWM_PERIOD*MAX_DUTY_PCT/100 using integer truncation.
- Update point: targets are applied only on the cnt==0 cycle, so outputs change only at period boundaries. No partial or glitched pulses.
- Registered outputs: hb_en[i] = (state RUN) && (cnt < active_duty[i]). One clock latency from cnt to pins.
- Per-channel FSM:
  - COAST: en=0, in=00.
  - RUN: in=01 for FWD, 10 for REV; en=PWM.
  - BRAKE: en=1 constant, in=11.
  - DEAD: en=0, in=00; a down-counter loaded with DEAD_PERIODS decrements each boundary; at 0 go to RUN in the new direction.
- Transitions at boundary:
  - Any state -> target state directly.
  - Exception: RUN(FWD) <-> RUN(REV) goes via DEAD.
  - A new reversal request during DEAD reloads the counter.
  - A COAST or BRAKE request during DEAD takes effect immediately at that boundary.
  - duty 0 in RUN gives en=0 with direction pins held.
- Estop: estop=1 sets stopped on the next edge. From the following cycle, all channels are forced to COAST outputs, without waiting for a boundary.
  - While stopped: cmd_ready=0, targets and active duty are cleared to COAST/0, and the dead counters are cleared.
  - estop_clr while estop=0 clears stopped; estop_clr while estop=1 is ignored.
  - estop and estop_clr in the same cycle: stop wins.
- rst mid-period: everything returns to reset values on that edge; the counter restarts at 0.

Optional Feature:
- Macro DRIVE_RAMP_EN.
- Defined: at each boundary, active_duty moves toward target duty by at most RAMP_STEP, up or down. Entering RUN from COAST, BRAKE or DEAD starts from duty 0. Estop bypasses the ramp and goes to 0 immediately.
- Undefined: active_duty = target duty at the boundary; RAMP_STEP is unused.

Decomposition:
- Package drive_pkg:
  - dir encoding constants (DIR_COAST/FWD/REV/BRAKE)
  - channel state encoding (CH_COAST, CH_RUN, CH_DEAD, CH_BRAKE)
  - bridge pin encoding helper function
- Natural sub-module: drive_pwm_channel, one per channel via generate. It holds the FSM, dead counter, ramp and comparator. The shared counter, command demux and estop latch live in the top module.

Test Plan:
- Base parameters for all scenarios: PWM_PERIOD=10, N_CH=2, MAX_DUTY_PCT=80, DEAD_PERIODS=2.
- Command ch0 FWD duty 5 -> from next boundary, ch0 in=01 and en high for 5 of every 10 clocks; ch1 stays en=0, in=00.
- Command ch1 REV duty 15 -> clamped to 8; en high 8 of 10 clocks, in=10.
- Reversal: ch0 running FWD duty 5, command REV duty 5 -> 2 full periods en=0, in=00, then in=10 with 5-clock pulses.
- Estop asserted mid-pulse at cnt=3 -> all en=0 and in=00 two edges later; stopped=1; cmd_ready=0.
  - estop_clr with estop high -> no change.
  - Drop estop, then pulse estop_clr -> stopped=0, cmd_ready=1, channels remain COAST.
- Two commands to ch0 in one period (FWD 3, then BRAKE) plus rst at cnt=6 of a later period -> only BRAKE is applied (en=1, in=11); after rst all outputs are 0 and cnt restarts at 0.
- With DRIVE_RAMP_EN and RAMP_STEP=2: FWD duty 7 from COAST -> successive periods show pulse widths 2, 4, 6, 7.

Source files
------------

// File: rtl/drive_pkg.sv
// Shared encodings for the H-bridge drive controller.
// Direction codes, channel states and bridge pin mapping.
package drive_pkg;

  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_FWD   = 2'b01;
  localparam logic [1:0] DIR_REV   = 2'b10;
  localparam logic [1:0] DIR_BRAKE = 2'b11;

  typedef enum logic [1:0] {
    CH_COAST = 2'd0,
    CH_RUN   = 2'd1,
    CH_DEAD  = 2'd2,
    CH_BRAKE = 2'd3
  } ch_state_e;

  // Returns {in1, in2}; a running bridge mirrors the direction code.
  function automatic logic [1:0] hb_pins(
    input ch_state_e  s,
    input logic [1:0] dir
  );
    logic [1:0] p;
    p = 2'b00;
    unique case (1'b1)
      (s == CH_RUN):   p = dir;
      (s == CH_BRAKE): p = 2'b11;
      default:         p = 2'b00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/drive_pwm_channel.sv
// One H-bridge channel: state machine, dead-time, duty and comparator.
// Optional duty ramp is built when DRIVE_RAMP_EN is defined.
module drive_pwm_channel
  import drive_pkg::*;
#(
  parameter int DUTY_W       = 20,
  parameter int DEAD_PERIODS = 2,
  parameter int RAMP_STEP    = 31250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_boundary,
  input  logic              i_stop,
  input  logic [DUTY_W-1:0] i_cnt,
  input  logic [1:0]        i_tgt_dir,
  input  logic [DUTY_W-1:0] i_tgt_duty,
  output logic              o_en,
  output logic              o_in1,
  output logic              o_in2
);

  localparam int DCW = $clog2(DEAD_PERIODS + 2);

  ch_state_e         r_state, w_state;
  logic [1:0]        r_dir, w_dir;
  logic [DCW-1:0]    r_dead, w_dead;
  logic [DUTY_W-1:0] r_duty, w_duty;
  logic              w_mot;
  logic              w_rev;
  logic [1:0]        w_pins;

`ifdef DRIVE_RAMP_EN
  localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP);
  logic [DUTY_W-1:0] w_base;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CH_COAST;
      r_dir   <= DIR_COAST;
      r_dead  <= '0;
      r_duty  <= '0;
    end else begin
      r_state <= w_state;
      r_dir   <= w_dir;
      r_dead  <= w_dead;
      r_duty  <= w_duty;
    end
  end

  always_comb begin
    w_state = r_state;
    w_dir   = r_dir;
    w_dead  = r_dead;
    w_duty  = r_duty;
    w_mot   = (i_tgt_dir == DIR_FWD) || (i_tgt_dir == DIR_REV);
    w_rev   = w_mot && (r_dir != i_tgt_dir) &&
              ((r_state == CH_RUN) || (r_state == CH_DEAD));
`ifdef DRIVE_RAMP_EN
    w_base  = '0;
`endif
    if (i_stop) begin
      w_state = CH_COAST;
      w_dir   = DIR_COAST;
      w_dead  = '0;
      w_duty  = '0;
    end else if (i_boundary) begin
      unique case (1'b1)
        (i_tgt_dir == DIR_COAST): begin
          w_state = CH_COAST;
          w_dir   = DIR_COAST;
          w_dead  = '0;
        end
        (i_tgt_dir == DIR_BRAKE): begin
          w_state = CH_BRAKE;
          w_dir   = DIR_BRAKE;
          w_dead  = '0;
        end
        (w_rev && DEAD_PERIODS > 0): begin
          w_state = CH_DEAD;
          w_dir   = i_tgt_dir;
          w_dead  = DCW'(DEAD_PERIODS);
        end
        (!w_rev && r_state == CH_DEAD &&
         r_dead > DCW'(1)): begin
          w_dead = r_dead - DCW'(1);
        end
        default: begin
          w_state = CH_RUN;
          w_dir   = i_tgt_dir;
          w_dead  = '0;
        end
      endcase
`ifdef DRIVE_RAMP_EN
      // A fresh RUN entry ramps up from zero.
      if (w_state == CH_RUN) begin
        w_base = (r_state == CH_RUN) ? r_duty : '0;
        if (i_tgt_duty > w_base)
          w_duty = (i_tgt_duty - w_base > STEP) ?
                   w_base + STEP : i_tgt_duty;
        else
          w_duty = (w_base - i_tgt_duty > STEP) ?
                   w_base - STEP : i_tgt_duty;
      end else begin
        w_duty = '0;
      end
`else
      w_duty = i_tgt_duty;
`endif
    end
  end

  assign w_pins = hb_pins(w_state, w_dir);

  always_ff @(posedge clk) begin
    if (rst || i_stop) begin
      o_en  <= 1'b0;
      o_in1 <= 1'b0;
      o_in2 <= 1'b0;
    end else begin
      o_en  <= (w_state == CH_BRAKE) ||
               ((w_state == CH_RUN) && (i_cnt < w_duty));
      o_in1 <= w_pins[1];
      o_in2 <= w_pins[0];
    end
  end

endmodule

// File: rtl/drive_pwm_ctrl.sv
// N-channel H-bridge PWM controller: period counter, command demux, estop.
// Define DRIVE_RAMP_EN to slew active duty by RAMP_STEP per period.
module drive_pwm_ctrl
  import drive_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int PWM_PERIOD   = 625000,
  parameter int DUTY_W       = 20,
  parameter int MAX_DUTY_PCT = 80,
  parameter int DEAD_PERIODS = 2,
  parameter int RAMP_STEP    = 31250,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [1:0]        cmd_dir,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              estop,
  input  logic              estop_clr,
  output logic [N_CH-1:0]   hb_en,
  output logic [N_CH-1:0]   hb_in1,
  output logic [N_CH-1:0]   hb_in2,
  output logic              period_start,
  output logic              stopped
);

  localparam logic [DUTY_W-1:0] MAX_DUTY =
    DUTY_W'(PWM_PERIOD * MAX_DUTY_PCT / 100);
  localparam logic [DUTY_W-1:0] CNT_LAST =
    DUTY_W'(PWM_PERIOD - 1);

  logic [DUTY_W-1:0] r_cnt;
  logic              r_stopped;
  logic [1:0]        r_tgt_dir  [N_CH];
  logic [DUTY_W-1:0] r_tgt_duty [N_CH];
  logic              w_boundary;
  logic              w_accept;
  logic [DUTY_W-1:0] w_duty;

  assign w_boundary   = (r_cnt == '0);
  assign w_accept     = cmd_valid && !r_stopped;
  assign w_duty       = (cmd_duty > MAX_DUTY) ? MAX_DUTY : cmd_duty;
  assign cmd_ready    = !r_stopped;
  assign stopped      = r_stopped;
  assign period_start = w_boundary && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_stopped <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_tgt_dir[i]  <= DIR_COAST;
        r_tgt_duty[i] <= '0;
      end
    end else begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      if (estop)
        r_stopped <= 1'b1;
      else if (estop_clr)
        r_stopped <= 1'b0;
      // Out-of-range channel numbers match no slot and are dropped.
      for (int i = 0; i < N_CH; i++) begin
        if (r_stopped) begin
          r_tgt_dir[i]  <= DIR_COAST;
          r_tgt_duty[i] <= '0;
        end else if (w_accept && cmd_ch == CH_W'(i)) begin
          r_tgt_dir[i]  <= cmd_dir;
          r_tgt_duty[i] <= w_duty;
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    drive_pwm_channel #(
      .DUTY_W       (DUTY_W),
      .DEAD_PERIODS (DEAD_PERIODS),
      .RAMP_STEP    (RAMP_STEP)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_boundary (w_boundary),
      .i_stop     (r_stopped),
      .i_cnt      (r_cnt),
      .i_tgt_dir  (r_tgt_dir[g]),
      .i_tgt_duty (r_tgt_duty[g]),
      .o_en       (hb_en[g]),
      .o_in1      (hb_in1[g]),
      .o_in2      (hb_in2[g])
    );
  end

endmodule

// File: tb/tb_drive_pwm_ctrl.sv
// Self-checking bench for drive_pwm_ctrl with a 10-clock PWM period.
// Per-period pin patterns are queued as expectations and compared when observed.
module tb_drive_pwm_ctrl;
  import drive_pkg::*;

  localparam int P = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [0:0]  cmd_ch = '0;
  logic [1:0]  cmd_dir = '0;
  logic [19:0] cmd_duty = '0;
  logic        estop = 1'b0;
  logic        estop_clr = 1'b0;
  logic [1:0]  hb_en, hb_in1, hb_in2;
  logic        period_start, stopped;

  drive_pwm_ctrl #(
    .N_CH(2), .PWM_PERIOD(P), .DUTY_W(20),
    .MAX_DUTY_PCT(80), .DEAD_PERIODS(2), .RAMP_STEP(2)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_dir(cmd_dir), .cmd_duty(cmd_duty),
    .estop(estop), .estop_clr(estop_clr),
    .hb_en(hb_en), .hb_in1(hb_in1), .hb_in2(hb_in2),
    .period_start(period_start), .stopped(stopped)
  );

  always #5 clk = ~clk;

  // Independent model of the shared period counter.
  int tcnt = 0;
  always @(posedge clk)
    if (rst) tcnt <= 0;
    else tcnt <= (tcnt == P - 1) ? 0 : tcnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    int         ch;
    logic [1:0] dir;
    int         duty;
    int         w0;
    logic [1:0] p0;
    int         w1;
    logic [1:0] p1;
  } vec_t;

  typedef struct {
    string       name;
    logic [9:0]  en0, en1;
    logic [19:0] pin0, pin1;
  } exp_t;

  vec_t vecs[11];
  exp_t sbq[$];

  function automatic logic [9:0] mask(int w);
    logic [10:0] m;
    m = (11'd1 << w) - 11'd1;
    return (w >= P) ? 10'h3FF : m[9:0];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cnt(int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tcnt != k && n < 3 * P);
    if (tcnt != k) chk("wait_cnt", tcnt, k);
  endtask

  task automatic push_exp(string name, int w0, logic [1:0] p0,
                          int w1, logic [1:0] p1);
    exp_t e;
    e.name = name;
    e.en0  = mask(w0);
    e.en1  = mask(w1);
    e.pin0 = {10{p0}};
    e.pin1 = {10{p1}};
    sbq.push_back(e);
  endtask

  // Pins lag the counter by one clock, so a pin period is tcnt 1..9,0.
  task automatic measure();
    logic [9:0]  en0, en1;
    logic [19:0] pin0, pin1;
    exp_t e;
    wait_cnt(1);
    for (int k = 0; k < P; k++) begin
      if (k > 0) @(negedge clk);
      en0[k] = hb_en[0];
      en1[k] = hb_en[1];
      pin0[2*k +: 2] = {hb_in1[0], hb_in2[0]};
      pin1[2*k +: 2] = {hb_in1[1], hb_in2[1]};
    end
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got no expectation for observed period");
    end else begin
      e = sbq.pop_front();
      chk({e.name, "_en0"}, en0, e.en0);
      chk({e.name, "_en1"}, en1, e.en1);
      chk({e.name, "_pin0"}, pin0, e.pin0);
      chk({e.name, "_pin1"}, pin1, e.pin1);
    end
  endtask

  task automatic cmd(int ch, logic [1:0] d, int duty);
    cmd_valid = 1'b1;
    cmd_ch    = 1'(ch);
    cmd_dir   = d;
    cmd_duty  = 20'(duty);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_en", hb_en, 0);
    chk("rst_in1", hb_in1, 0);
    chk("rst_in2", hb_in2, 0);
    chk("rst_stopped", stopped, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_pstart", period_start, 0);
    rst = 1'b0;
    #1;
    chk("pstart_cnt0", period_start, 1);
    @(negedge clk);
    chk("pstart_cnt1", period_start, 0);

`ifndef DRIVE_RAMP_EN
    vecs[0]  = '{"fwd5",     0, DIR_FWD,   5,  5, DIR_FWD,   0, DIR_COAST};
    vecs[1]  = '{"rev_clamp",1, DIR_REV,   15, 5, DIR_FWD,   8, DIR_REV};
    vecs[2]  = '{"brake",    0, DIR_BRAKE, 0,  10, DIR_BRAKE, 8, DIR_REV};
    vecs[3]  = '{"coast",    0, DIR_COAST, 0,  0, DIR_COAST, 8, DIR_REV};
    vecs[4]  = '{"fwd0",     0, DIR_FWD,   0,  0, DIR_FWD,   8, DIR_REV};
    vecs[5]  = '{"fwd8",     0, DIR_FWD,   8,  8, DIR_FWD,   8, DIR_REV};
    vecs[6]  = '{"fwd9clmp", 0, DIR_FWD,   9,  8, DIR_FWD,   8, DIR_REV};
    vecs[7]  = '{"brake1",   1, DIR_BRAKE, 3,  8, DIR_FWD,  10, DIR_BRAKE};
    vecs[8]  = '{"coast1",   1, DIR_COAST, 0,  8, DIR_FWD,   0, DIR_COAST};
    vecs[9]  = '{"fwd1",     0, DIR_FWD,   1,  1, DIR_FWD,   0, DIR_COAST};
    vecs[10] = '{"fwd5b",    0, DIR_FWD,   5,  5, DIR_FWD,   0, DIR_COAST};

    for (int i = 0; i < 11; i++) begin
      wait_cnt(5);
      cmd(vecs[i].ch, vecs[i].dir, vecs[i].duty);
      push_exp(vecs[i].name, vecs[i].w0, vecs[i].p0,
               vecs[i].w1, vecs[i].p1);
      measure();
    end

    // FWD -> REV passes through two dead periods.
    wait_cnt(5);
    cmd(0, DIR_REV, 5);
    push_exp("rev_dead_a", 0, DIR_COAST, 0, DIR_COAST);
    push_exp("rev_dead_b", 0, DIR_COAST, 0, DIR_COAST);
    push_exp("rev_run",    5, DIR_REV,   0, DIR_COAST);
    repeat (3) measure();

    // A second reversal during dead-time reloads the counter.
    wait_cnt(5);
    cmd(0, DIR_FWD, 5);
    push_exp("rld_dead_1", 0, DIR_COAST, 0, DIR_COAST);
    measure();
    wait_cnt(2);
    cmd(0, DIR_REV, 5);
    push_exp("rld_dead_3", 0, DIR_COAST, 0, DIR_COAST);
    push_exp("rld_dead_4", 0, DIR_COAST, 0, DIR_COAST);
    push_exp("rld_run",    5, DIR_REV,   0, DIR_COAST);
    repeat (3) measure();

    // Emergency stop mid-pulse.
    wait_cnt(3);
    estop = 1'b1;
    @(negedge clk);
    chk("estop_stopped", stopped, 1);
    chk("estop_ready", cmd_ready, 0);
    chk("estop_en_lag", hb_en[0], 1);
    @(negedge clk);
    chk("estop_en", hb_en, 0);
    chk("estop_in1", hb_in1, 0);
    chk("estop_in2", hb_in2, 0);
    estop_clr = 1'b1;
    @(negedge clk);
    estop_clr = 1'b0;
    chk("clr_ignored", stopped, 1);
    estop = 1'b0;
    repeat (2) @(negedge clk);
    chk("stop_latched", stopped, 1);
    estop_clr = 1'b1;
    @(negedge clk);
    estop_clr = 1'b0;
    chk("clr_stopped", stopped, 0);
    chk("clr_ready", cmd_ready, 1);
    push_exp("post_clr", 0, DIR_COAST, 0, DIR_COAST);
    measure();

    estop = 1'b1;
    estop_clr = 1'b1;
    @(negedge clk);
    estop = 1'b0;
    estop_clr = 1'b0;
    chk("stop_wins", stopped, 1);
    estop_clr = 1'b1;
    @(negedge clk);
    estop_clr = 1'b0;
    chk("clr_again", stopped, 0);

    // Last command in a period wins; then reset mid-period.
    wait_cnt(2);
    cmd(0, DIR_FWD, 3);
    cmd(0, DIR_BRAKE, 0);
    push_exp("last_wins", 10, DIR_BRAKE, 0, DIR_COAST);
    measure();
    wait_cnt(6);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_en", hb_en, 0);
    chk("mrst_in1", hb_in1, 0);
    chk("mrst_in2", hb_in2, 0);
    rst = 1'b0;
    #1;
    chk("mrst_cnt0", period_start, 1);
    chk("mrst_ready", cmd_ready, 1);
    push_exp("after_rst", 0, DIR_COAST, 0, DIR_COAST);
    measure();
`else
    wait_cnt(5);
    cmd(0, DIR_FWD, 7);
    push_exp("ramp_up2", 2, DIR_FWD, 0, DIR_COAST);
    push_exp("ramp_up4", 4, DIR_FWD, 0, DIR_COAST);
    push_exp("ramp_up6", 6, DIR_FWD, 0, DIR_COAST);
    push_exp("ramp_up7", 7, DIR_FWD, 0, DIR_COAST);
    repeat (4) measure();
    wait_cnt(5);
    cmd(0, DIR_FWD, 1);
    push_exp("ramp_dn5", 5, DIR_FWD, 0, DIR_COAST);
    push_exp("ramp_dn3", 3, DIR_FWD, 0, DIR_COAST);
    push_exp("ramp_dn1", 1, DIR_FWD, 0, DIR_COAST);
    repeat (3) measure();
`endif

    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: got %0d unchecked expectations", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
